// File: rtl/slurm16_instruction_cache.sv
// Direct-mapped read-only instruction cache: 1-cycle hits from a synchronous-read data array,
// misses refill a whole line from memory by a word-serial burst.
module slurm16_instruction_cache #(
    parameter int ADDR_BITS       = 15,
    parameter int INDEX_BITS      = 6,
    parameter int LINE_WORDS_LOG2 = 2
) (
    input  logic                 CLK,
    input  logic                 RSTb,
    input  logic [ADDR_BITS-1:0] cpu_address,
    output logic [15:0]          cpu_data,
    output logic                 cpu_success,
    input  logic                 flush,
    output logic [ADDR_BITS-1:0] mem_address,
    output logic                 mem_rd,
    input  logic [15:0]          mem_data,
    input  logic                 mem_valid,
    output logic                 busy
);

    localparam int TAG_BITS  = ADDR_BITS - INDEX_BITS - LINE_WORDS_LOG2;
    localparam int LINE_BITS = ADDR_BITS - LINE_WORDS_LOG2;
    localparam int LINES     = 1 << INDEX_BITS;
    localparam int DATA_BITS = INDEX_BITS + LINE_WORDS_LOG2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [LINE_BITS-1:0]       look_line_q, look_line_d;
    logic                       look_valid_q, look_valid_d;
    logic [LINE_BITS-1:0]       fill_line_q, fill_line_d;
    logic [LINE_WORDS_LOG2-1:0] cnt_q, cnt_d;
    logic                       flush_pending_q, flush_pending_d;
    logic [LINES-1:0]           valid_q, valid_d;

    logic [15:0]         data_mem [1 << DATA_BITS];
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [15:0]         rd_word_q;
    logic [TAG_BITS-1:0] rd_tag_q;

    logic fill_we;
    logic tag_we;
    logic hit;

    // look_valid_q marks that the registered array reads belong to a genuine IDLE lookup;
    // it is low in the first IDLE cycle after a fill so that cycle only re-samples the address.
    assign hit = (state_q == ST_IDLE) && look_valid_q
                 && valid_q[look_line_q[INDEX_BITS-1:0]]
                 && (rd_tag_q == look_line_q[LINE_BITS-1:INDEX_BITS]);

    always_comb begin
        state_d         = state_q;
        look_line_d     = cpu_address[ADDR_BITS-1:LINE_WORDS_LOG2];
        look_valid_d    = 1'b0;
        fill_line_d     = fill_line_q;
        cnt_d           = cnt_q;
        flush_pending_d = flush_pending_q;
        valid_d         = valid_q;
        fill_we         = 1'b0;
        tag_we          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                look_valid_d = 1'b1;
                if (flush) begin
                    valid_d = '0;
                end
                if (look_valid_q && !hit) begin
                    state_d      = ST_FILL;
                    fill_line_d  = look_line_q;
                    cnt_d        = '0;
                    look_valid_d = 1'b0;
                end
            end
            ST_FILL: begin
                if (flush) begin
                    flush_pending_d = 1'b1;
                end
                // mem_rd/mem_address act as a held request; each mem_valid cycle transfers
                // one word for the current mem_address and advances the burst.
                if (mem_valid) begin
                    fill_we = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_d         = ST_IDLE;
                        tag_we          = 1'b1;
                        flush_pending_d = 1'b0;
                        if (flush_pending_q || flush) begin
                            valid_d = '0;
                        end else begin
                            valid_d[fill_line_q[INDEX_BITS-1:0]] = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state_q         <= ST_IDLE;
            look_line_q     <= '0;
            look_valid_q    <= 1'b0;
            fill_line_q     <= '0;
            cnt_q           <= '0;
            flush_pending_q <= 1'b0;
            valid_q         <= '0;
        end else begin
            state_q         <= state_d;
            look_line_q     <= look_line_d;
            look_valid_q    <= look_valid_d;
            fill_line_q     <= fill_line_d;
            cnt_q           <= cnt_d;
            flush_pending_q <= flush_pending_d;
            valid_q         <= valid_d;
        end
    end

    // Arrays carry no reset; validity lives only in valid_q.
    always_ff @(posedge CLK) begin
        if (fill_we) begin
            data_mem[{fill_line_q[INDEX_BITS-1:0], cnt_q}] <= mem_data;
        end
        if (tag_we) begin
            tag_mem[fill_line_q[INDEX_BITS-1:0]] <= fill_line_q[LINE_BITS-1:INDEX_BITS];
        end
        rd_word_q <= data_mem[cpu_address[DATA_BITS-1:0]];
        rd_tag_q  <= tag_mem[cpu_address[LINE_WORDS_LOG2 +: INDEX_BITS]];
    end

    assign busy        = (state_q == ST_FILL);
    assign mem_rd      = busy;
    assign mem_address = busy ? {fill_line_q, cnt_q} : '0;
    assign cpu_success = hit;
    assign cpu_data    = hit ? rd_word_q : 16'h0000;

endmodule
